// File: rtl/lfsr_scramble_66.sv
// 64b/66b transmit scrambler (x^58 + x^39 + 1) with a registered ready/valid output stage.
// Optional per-beat scrambler bypass is enabled by defining LFSR_SCRAMBLE_BYPASS_EN.
module lfsr_scramble_66 #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    HDR_WIDTH  = 2,
    parameter int                    LFSR_WIDTH = 58,
    parameter logic [LFSR_WIDTH-1:0] LFSR_INIT  = {LFSR_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [HDR_WIDTH-1:0]  hdr_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [HDR_WIDTH-1:0]  hdr_out,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef LFSR_SCRAMBLE_BYPASS_EN
    ,
    input  logic                  scr_bypass
`endif
);

    // Handshake: a beat moves on a rising edge where valid && ready are both high.
    // in_ready depends only on the output register state and out_ready, never on in_valid.

    logic [LFSR_WIDTH-1:0] r_state;
    logic [DATA_WIDTH-1:0] r_data;
    logic [HDR_WIDTH-1:0]  r_hdr;
    logic                  r_valid;

    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_scrambled;
    logic [LFSR_WIDTH-1:0] w_next_state;
    logic [DATA_WIDTH-1:0] w_data_sel;
    logic [LFSR_WIDTH-1:0] w_state_sel;

    assign in_ready  = !r_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign data_out  = r_data;
    assign hdr_out   = r_hdr;
    assign out_valid = r_valid;

    // ext holds the transmitted bit stream oldest-first: the 58 previous scrambled
    // bits followed by this beat's 64, so every tap is a fixed backward offset.
    always_comb begin
        logic [LFSR_WIDTH+DATA_WIDTH-1:0] ext;
        ext          = '0;
        w_scrambled  = '0;
        w_next_state = '0;
        for (int m = 0; m < LFSR_WIDTH; m++) begin
            ext[m] = r_state[LFSR_WIDTH-1-m];
        end
        for (int i = 0; i < DATA_WIDTH; i++) begin
            ext[LFSR_WIDTH+i] = data_in[i] ^ ext[LFSR_WIDTH+i-39] ^ ext[i];
        end
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_scrambled[i] = ext[LFSR_WIDTH+i];
        end
        for (int j = 0; j < LFSR_WIDTH; j++) begin
            w_next_state[j] = ext[LFSR_WIDTH+DATA_WIDTH-1-j];
        end
    end

`ifdef LFSR_SCRAMBLE_BYPASS_EN
    assign w_data_sel  = scr_bypass ? data_in : w_scrambled;
    assign w_state_sel = scr_bypass ? r_state : w_next_state;
`else
    assign w_data_sel  = w_scrambled;
    assign w_state_sel = w_next_state;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LFSR_INIT;
            r_data  <= '0;
            r_hdr   <= '0;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_state <= w_state_sel;
            r_data  <= w_data_sel;
            r_hdr   <= hdr_in;
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
